// File: rtl/shift_out_nbits.sv
// shift_out_nbits
//   Serializes an N-bit parallel word onto a single output, LSB first.
//   A word is accepted only while idle. Each enabled clock edge advances
//   one bit. A one-cycle done pulse marks the return to idle after the
//   last bit has been presented.
//
// Ports
//   clk        : clock, all state updates on the rising edge
//   reset      : asynchronous, active-high reset
//   en         : shift enable, sampled on the rising edge
//   load       : parallel-load request, honoured only when ready
//   d[N-1:0]   : parallel word to serialize
//   ready      : high while idle (a load will be accepted)
//   sout       : serial data out, LSB first, forced low while idle
//   sout_valid : high while sout carries a word bit
//   done       : single-cycle pulse coincident with the return to idle
module shift_out_nbits #(
    parameter int unsigned N = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         load,
    input  logic [N-1:0] d,
    output logic         ready,
    output logic         sout,
    output logic         sout_valid,
    output logic         done
);

    localparam int unsigned    CW   = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0]  LAST = CW'(N - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t          state, state_nxt;
    logic [N-1:0]    shreg, shreg_nxt;
    logic [CW-1:0]   cnt,   cnt_nxt;
    logic            done_q, done_nxt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            shreg  <= '0;
            cnt    <= '0;
            done_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            shreg  <= shreg_nxt;
            cnt    <= cnt_nxt;
            done_q <= done_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        shreg_nxt = shreg;
        cnt_nxt   = cnt;
        done_nxt  = 1'b0;
        unique case (state)
            IDLE: begin
                if (load) begin
                    shreg_nxt = d;
                    cnt_nxt   = '0;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                // load is deliberately ignored here; only en advances the word
                if (en) begin
                    shreg_nxt = {1'b0, shreg[N-1:1]};
                    cnt_nxt   = cnt + CW'(1);
                    if (cnt == LAST) begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign ready      = (state == IDLE);
    assign sout_valid = (state == SHIFT);
    assign sout       = sout_valid & shreg[0];
    assign done       = done_q;

endmodule

// File: tb/tb_shift_out_nbits.sv
// tb_shift_out_nbits
//   Directed bench for shift_out_nbits with N=8. A table of per-cycle
//   {inputs, expected outputs} records covers reset-with-load, a full-rate
//   word, an ignored mid-word load and back-to-back words across the done
//   cycle. Hand-written sequences cover en toggling and asynchronous reset
//   in the middle of a word.
module tb_shift_out_nbits;

    localparam int unsigned N = 8;

    logic         clk;
    logic         reset;
    logic         en;
    logic         load;
    logic [N-1:0] d;
    logic         ready;
    logic         sout;
    logic         sout_valid;
    logic         done;

    int unsigned n_checks;
    int unsigned n_fail;

    typedef struct {
        logic         rst;
        logic         ld;
        logic         en;
        logic [N-1:0] d;
        logic         exp_ready;
        logic         exp_sout;
        logic         exp_valid;
        logic         exp_done;
    } vec_t;

    vec_t        tbl [64];
    int unsigned nv;

    shift_out_nbits #(.N(N)) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .load       (load),
        .d          (d),
        .ready      (ready),
        .sout       (sout),
        .sout_valid (sout_valid),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic got, input logic exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input logic r, input logic s,
                           input logic v, input logic dn);
        chk({tag, " ready"},      ready,      r);
        chk({tag, " sout"},       sout,       s);
        chk({tag, " sout_valid"}, sout_valid, v);
        chk({tag, " done"},       done,       dn);
    endtask

    // advance past the next rising edge; outputs are sampled 1 time unit later
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic rst, input logic ld, input logic e, input logic [N-1:0] dv,
                       input logic r, input logic s, input logic v, input logic dn);
        tbl[nv].rst       = rst;
        tbl[nv].ld        = ld;
        tbl[nv].en        = e;
        tbl[nv].d         = dv;
        tbl[nv].exp_ready = r;
        tbl[nv].exp_sout  = s;
        tbl[nv].exp_valid = v;
        tbl[nv].exp_done  = dn;
        nv++;
    endtask

    logic [N-1:0] w81;
    int unsigned  done_cnt;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        nv       = 0;
        reset    = 1'b1;
        load     = 1'b0;
        en       = 1'b0;
        d        = '0;

        // reset held with load=1, d=FF: nothing taken
        add(1, 1, 0, 8'hFF, 1, 0, 0, 0);
        add(0, 0, 0, 8'hFF, 1, 0, 0, 0);
        // A5 at full rate: 1,0,1,0,0,1,0,1 then done
        add(0, 1, 1, 8'hA5, 0, 1, 1, 0);
        add(0, 0, 1, 8'h00, 0, 0, 1, 0);
        add(0, 0, 1, 8'h00, 0, 1, 1, 0);
        add(0, 0, 1, 8'h00, 0, 0, 1, 0);
        add(0, 0, 1, 8'h00, 0, 0, 1, 0);
        add(0, 0, 1, 8'h00, 0, 1, 1, 0);
        add(0, 0, 1, 8'h00, 0, 0, 1, 0);
        add(0, 0, 1, 8'h00, 0, 1, 1, 0);
        add(0, 0, 1, 8'h00, 1, 0, 0, 1);
        add(0, 0, 0, 8'h00, 1, 0, 0, 0);
        // 3C with a load of FF around bit 3: output stays 0,0,1,1,1,1,0,0
        add(0, 1, 1, 8'h3C, 0, 0, 1, 0);
        add(0, 0, 1, 8'h00, 0, 0, 1, 0);
        add(0, 0, 1, 8'h00, 0, 1, 1, 0);
        add(0, 1, 1, 8'hFF, 0, 1, 1, 0);
        add(0, 1, 1, 8'hFF, 0, 1, 1, 0);
        add(0, 0, 1, 8'h00, 0, 1, 1, 0);
        add(0, 0, 1, 8'h00, 0, 0, 1, 0);
        add(0, 0, 1, 8'h00, 0, 0, 1, 0);
        add(0, 0, 1, 8'h00, 1, 0, 0, 1);
        add(0, 0, 0, 8'h00, 1, 0, 0, 0);
        // 55 then 0F loaded during the done cycle (one bubble)
        add(0, 1, 1, 8'h55, 0, 1, 1, 0);
        add(0, 0, 1, 8'h00, 0, 0, 1, 0);
        add(0, 0, 1, 8'h00, 0, 1, 1, 0);
        add(0, 0, 1, 8'h00, 0, 0, 1, 0);
        add(0, 0, 1, 8'h00, 0, 1, 1, 0);
        add(0, 0, 1, 8'h00, 0, 0, 1, 0);
        add(0, 0, 1, 8'h00, 0, 1, 1, 0);
        add(0, 0, 1, 8'h00, 0, 0, 1, 0);
        add(0, 0, 1, 8'h00, 1, 0, 0, 1);
        add(0, 1, 1, 8'h0F, 0, 1, 1, 0);
        add(0, 0, 1, 8'h00, 0, 1, 1, 0);
        add(0, 0, 1, 8'h00, 0, 1, 1, 0);
        add(0, 0, 1, 8'h00, 0, 1, 1, 0);
        add(0, 0, 1, 8'h00, 0, 0, 1, 0);
        add(0, 0, 1, 8'h00, 0, 0, 1, 0);
        add(0, 0, 1, 8'h00, 0, 0, 1, 0);
        add(0, 0, 1, 8'h00, 0, 0, 1, 0);
        add(0, 0, 1, 8'h00, 1, 0, 0, 1);
        add(0, 0, 0, 8'h00, 1, 0, 0, 0);

        step();
        step();
        for (int i = 0; i < int'(nv); i++) begin
            reset = tbl[i].rst;
            load  = tbl[i].ld;
            en    = tbl[i].en;
            d     = tbl[i].d;
            step();
            chk_all($sformatf("row%0d", i), tbl[i].exp_ready, tbl[i].exp_sout,
                    tbl[i].exp_valid, tbl[i].exp_done);
        end

        // 81 with en toggling: each bit held two cycles, 16 SHIFT cycles, one done
        w81      = 8'h81;
        done_cnt = 0;
        load     = 1'b1;
        d        = w81;
        en       = 1'b1;
        step();
        load = 1'b0;
        d    = '0;
        chk_all("t81 c0", 1'b0, w81[0], 1'b1, 1'b0);
        for (int c = 1; c <= 16; c++) begin
            en = (c % 2 == 0);
            step();
            if (done) done_cnt++;
            if (c < 16)
                chk_all($sformatf("t81 c%0d", c), 1'b0, w81[c/2], 1'b1, 1'b0);
            else
                chk_all("t81 end", 1'b1, 1'b0, 1'b0, 1'b1);
        end
        en = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step();
            if (done) done_cnt++;
        end
        n_checks++;
        if (done_cnt != 1) begin
            n_fail++;
            $display("FAIL t81 done_count: got %0d expected 1", done_cnt);
        end

        // F0 with reset asserted after bit 4: immediate idle, no done
        load = 1'b1;
        d    = 8'hF0;
        en   = 1'b1;
        step();
        load = 1'b0;
        for (int c = 1; c <= 4; c++) step();
        chk_all("tF0 bit4", 1'b0, 1'b1, 1'b1, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        chk_all("tF0 async", 1'b1, 1'b0, 1'b0, 1'b0);
        done_cnt = 0;
        for (int c = 0; c < 2; c++) begin
            step();
            if (done) done_cnt++;
        end
        reset = 1'b0;
        for (int c = 0; c < 2; c++) begin
            step();
            if (done) done_cnt++;
        end
        n_checks++;
        if (done_cnt != 0) begin
            n_fail++;
            $display("FAIL tF0 done_after_reset: got %0d expected 0", done_cnt);
        end
        chk_all("tF0 idle", 1'b1, 1'b0, 1'b0, 1'b0);

        // first edge after reset release accepts a load
        reset = 1'b1;
        step();
        reset = 1'b0;
        load  = 1'b1;
        d     = 8'h02;
        en    = 1'b0;
        step();
        load = 1'b0;
        chk_all("post_rst load", 1'b0, 1'b0, 1'b1, 1'b0);
        en = 1'b1;
        step();
        chk_all("post_rst bit1", 1'b0, 1'b1, 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/shift_out_nbits.md
SHIFT_OUT_NBITS -- requirements
Module: shift_out_nbits

Interface
REQ-001 The block SHALL have parameter N, default 8, meaning the parallel word width in bits; legal values are N >= 2.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock, with all state updating on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port en, input, 1 bit: shift enable, sampled on clk rising edge.
REQ-005 The block SHALL have port load, input, 1 bit: parallel-load request.
REQ-006 The block SHALL have port d, input, N bits: parallel word to serialize.
REQ-007 The block SHALL have port ready, output, 1 bit: high when a load will be accepted.
REQ-008 The block SHALL have port sout, output, 1 bit: serial data out, LSB first.
REQ-009 The block SHALL have port sout_valid, output, 1 bit: high while sout carries a word bit.
REQ-010 The block SHALL have port done, output, 1 bit: one-cycle pulse after the last bit shifts out.

Function
REQ-011 The block SHALL implement a two-state FSM with states IDLE and SHIFT.
REQ-012 The block SHALL hold an internal N-bit shift register shreg and a bit counter cnt of width $clog2(N).
REQ-013 The block SHALL drive ready = 1 in IDLE and 0 in SHIFT, decoded combinationally from the state.
REQ-014 The block SHALL accept a load in IDLE when load=1 at a rising edge: shreg <= d, cnt <= 0, state <= SHIFT.
REQ-015 A load arriving while in SHIFT SHALL be ignored with no effect on shreg, cnt or state.
REQ-016 The block SHALL drive sout = shreg[0] in SHIFT and force sout = 0 in IDLE.
REQ-017 The block SHALL drive sout_valid = 1 exactly when in SHIFT.
REQ-018 In SHIFT with en=1 at a rising edge, the block SHALL update shreg <= {1'b0, shreg[N-1:1]} and cnt <= cnt+1.
REQ-019 In SHIFT with en=0, the block SHALL hold shreg, cnt and state unchanged, with sout stable.
REQ-020 In SHIFT with en=1 and cnt = N-1, the block SHALL set state <= IDLE and register done <= 1 for that edge.
REQ-021 The block SHALL hold done = 0 at every other edge, so done is a single-cycle pulse coincident with the return to IDLE.
REQ-022 en SHALL have no effect in IDLE.
REQ-023 A load in the cycle done is high SHALL be accepted, since the block is already in IDLE, giving one bubble cycle between words.
REQ-024 Word latency SHALL be: first bit valid in the cycle after the load edge; the word occupies exactly N en-qualified edges.
REQ-025 The bit order SHALL be d[0] first and d[N-1] last.

Reset
REQ-026 reset=1 SHALL immediately, without waiting for a clock edge, force state=IDLE, shreg=0, cnt=0 and done=0, giving ready=1, sout=0 and sout_valid=0.
REQ-027 Reset asserted mid-word SHALL discard the word, with no done pulse generated.
REQ-028 After reset deasserts, the first rising edge SHALL accept a load.

Verification (N=8)
REQ-029 The bench SHALL cover: reset=1 with load=1, d=8'hFF -> ready=1, sout=0, sout_valid=0, done=0, and no load taken.
REQ-030 The bench SHALL cover: load d=8'hA5 with en held 1 -> sout sequence 1,0,1,0,0,1,0,1 over 8 cycles, done high one cycle with ready=1 in that cycle.
REQ-031 The bench SHALL cover: load 8'h81 with en toggling 1,0,1,0,... -> each bit held for 2 cycles, 16 SHIFT cycles total, done once.
REQ-032 The bench SHALL cover: load 8'h3C, then load d=8'hFF at bit 3 -> the load is ignored and the output is still 0,0,1,1,1,1,0,0.
REQ-033 The bench SHALL cover: load 8'hF0, then assert reset after bit 4 -> sout_valid=0 and ready=1 immediately, with no done pulse.
REQ-034 The bench SHALL cover: load 8'h55 with load asserted during the done cycle with d=8'h0F -> a second word 1,1,1,1,0,0,0,0 follows after one bubble.
